// File: rtl/cfg_pkg.sv
// Shared definitions for the serial configuration transmitter and the
// config_block receivers: FSM state encoding and default frame geometry.
package cfg_pkg;

    localparam int CFG_ID_WIDTH   = 3;
    localparam int CFG_WORD_WIDTH = 16;
    localparam int CFG_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } cfg_state_e;

    // States in which the transmitter may still take payload words.
    function automatic logic is_tx_state(input cfg_state_e st);
        return (st == ST_HDR) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// Two-entry payload word buffer with push/pop in the same cycle and a
// synchronous flush used to discard leftovers on an aborted frame.
module cfg_word_fifo
    import cfg_pkg::*;
#(
    parameter int WIDTH = CFG_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             crst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [0:1];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = mem_q[rd_ptr_q];

    // Qualify requests: a push into a full buffer is allowed only when a pop frees a slot.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; flush has priority over any push in the same cycle.
    always_ff @(posedge clk) begin
        if (crst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cfg_tx.sv
// Serial configuration frame transmitter: ID header (MSB first) followed by
// len payload words (LSB first), a one-cycle gap, and done/err status pulses.
module cfg_tx
    import cfg_pkg::*;
#(
    parameter int ID_WIDTH   = CFG_ID_WIDTH,
    parameter int WORD_WIDTH = CFG_WORD_WIDTH,
    parameter int LEN_WIDTH  = CFG_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  crst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  cfg_out_start,
    output logic                  cfg_bit_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int HCW = $clog2(ID_WIDTH + 1);
    localparam int BCW = $clog2(WORD_WIDTH + 1);
    localparam logic [HCW-1:0]       HDR_LAST = HCW'(ID_WIDTH - 1);
    localparam logic [BCW-1:0]       BIT_LAST = BCW'(WORD_WIDTH - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

    cfg_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [HCW-1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_WIDTH-1:0]  acc_cnt_q, acc_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  aborted_q, aborted_d;
    logic                  cmd_ready_q;

    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  fifo_flush_s;
    logic [WORD_WIDTH-1:0] fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    cfg_word_fifo #(
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .crst        (crst),
        .push_i      (fifo_push_s),
        .push_data_i (wr_data),
        .pop_i       (fifo_pop_s),
        .flush_i     (fifo_flush_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = (state_q != ST_IDLE);

    // Payload acceptance: only while transmitting, with buffer room, and until len words are in.
    always_comb begin
        wr_ready    = is_tx_state(state_q) && !fifo_full_s && (acc_cnt_q < len_q);
        fifo_push_s = wr_valid && wr_ready;
    end

    // Next-state, serializer datapath and frame outputs.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        len_d         = len_q;
        hdr_cnt_d     = hdr_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        shift_d       = shift_q;
        aborted_d     = aborted_q;
        fifo_pop_s    = 1'b0;
        fifo_flush_s  = 1'b0;
        cfg_out_start = 1'b0;
        cfg_bit_out   = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        if (fifo_push_s) begin
            acc_cnt_d = acc_cnt_q + LEN_ONE;
        end else begin
            acc_cnt_d = acc_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    id_d      = cmd_id;
                    len_d     = cmd_len;
                    hdr_cnt_d = {HCW{1'b0}};
                    acc_cnt_d = {LEN_WIDTH{1'b0}};
                    aborted_d = 1'b0;
                    state_d   = ST_HDR;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_HDR: begin
                cfg_bit_out   = id_q[ID_WIDTH-1];
                cfg_out_start = (hdr_cnt_q == {HCW{1'b0}});
                id_d          = id_q << 1'b1;
                if (hdr_cnt_q == HDR_LAST) begin
                    bit_cnt_d  = {BCW{1'b0}};
                    word_cnt_d = {LEN_WIDTH{1'b0}};
                    if (len_q == {LEN_WIDTH{1'b0}}) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    hdr_cnt_d = hdr_cnt_q + HCW'(1'b1);
                end
            end
            ST_DATA: begin
                if ((bit_cnt_q == {BCW{1'b0}}) && fifo_empty_s) begin
                    // Next word is due but nothing is buffered: abort the frame.
                    err          = 1'b1;
                    fifo_flush_s = 1'b1;
                    aborted_d    = 1'b1;
                    state_d      = ST_GAP;
                end else begin
                    if (bit_cnt_q == {BCW{1'b0}}) begin
                        cfg_bit_out = fifo_head_s[0];
                        fifo_pop_s  = 1'b1;
                        shift_d     = fifo_head_s >> 1'b1;
                    end else begin
                        cfg_bit_out = shift_q[0];
                        shift_d     = shift_q >> 1'b1;
                    end
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = {BCW{1'b0}};
                        if (word_cnt_q == (len_q - LEN_ONE)) begin
                            state_d = ST_GAP;
                        end else begin
                            word_cnt_d = word_cnt_q + LEN_ONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1'b1);
                    end
                end
            end
            ST_GAP: begin
                done    = !aborted_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without status pulses.
    always_ff @(posedge clk) begin
        if (crst) begin
            state_q     <= ST_IDLE;
            id_q        <= {ID_WIDTH{1'b0}};
            len_q       <= {LEN_WIDTH{1'b0}};
            hdr_cnt_q   <= {HCW{1'b0}};
            bit_cnt_q   <= {BCW{1'b0}};
            word_cnt_q  <= {LEN_WIDTH{1'b0}};
            acc_cnt_q   <= {LEN_WIDTH{1'b0}};
            shift_q     <= {WORD_WIDTH{1'b0}};
            aborted_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            hdr_cnt_q   <= hdr_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            shift_q     <= shift_d;
            aborted_q   <= aborted_d;
            cmd_ready_q <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cfg_tx.sv
// Directed bench for cfg_tx: hand-computed serial bit streams and status timing.
module tb_cfg_tx;

    logic        clk;
    logic        crst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        cfg_out_start;
    logic        cfg_bit_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_pass;

    logic [15:0] words [0:3];

    logic [63:0] r_bits;
    int          r_nbits;
    int          r_starts;
    int          r_dones;
    int          r_errs;
    int          r_tdone;
    int          r_terr;
    int          r_acc;
    int          r_wrhi;
    logic [7:0]  r_wrtrace;
    logic        r_timeout;

    cfg_tx dut (
        .clk           (clk),
        .crst          (crst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_id        (cmd_id),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, feeds words[0..nw-1] as fast as accepted and records the frame.
    task automatic send_frame(input logic [2:0] id, input logic [7:0] len, input int nw);
        int  t0;
        int  idx;
        bit  fin;
        bit  acc_now;
        bit  cmd_hs;
        r_bits = 64'h0; r_nbits = 0; r_starts = 0; r_dones = 0; r_errs = 0;
        r_tdone = -1; r_terr = -1; r_acc = 0; r_wrhi = 0; r_wrtrace = 8'h00; r_timeout = 1'b0;
        t0 = -1; idx = 0; fin = 1'b0;
        cmd_id = id; cmd_len = len; cmd_valid = 1'b1;
        wr_valid = (idx < nw);
        wr_data  = (idx < 4) ? words[idx] : 16'h0000;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (cfg_out_start) begin
                r_starts++;
                if (t0 < 0) t0 = c;
            end
            if (t0 >= 0) begin
                if (busy) begin
                    if (r_nbits < 64) r_bits[r_nbits] = cfg_bit_out;
                    r_nbits++;
                end else begin
                    fin = 1'b1;
                end
                if (c - t0 < 8) r_wrtrace[c - t0] = wr_ready;
                if (done) begin r_dones++; r_tdone = c - t0; end
                if (err)  begin r_errs++;  r_terr  = c - t0; end
            end
            if (wr_ready) r_wrhi++;
            acc_now = wr_valid && wr_ready;
            cmd_hs  = cmd_valid && cmd_ready;
            if (acc_now) r_acc++;
            if (!fin) begin
                tick();
                if (cmd_hs) cmd_valid = 1'b0;
                if (acc_now) idx++;
                wr_valid = (idx < nw);
                wr_data  = (idx < 4) ? words[idx] : 16'h0000;
            end
        end
        if (!fin) r_timeout = 1'b1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
    endtask

    task automatic test_reset();
        crst = 1'b1; cmd_valid = 1'b0; cmd_id = 3'd0; cmd_len = 8'd0;
        wr_valid = 1'b0; wr_data = 16'h0000;
        tick(); tick();
        n_checks++;
        if ({cfg_out_start, cfg_bit_out, busy, done, err, wr_ready, cmd_ready} !== 7'b0)
            $display("FAIL reset_outputs: got %b want 0000000",
                     {cfg_out_start, cfg_bit_out, busy, done, err, wr_ready, cmd_ready});
        else n_pass++;
        crst = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_release_ready_early: got %b want 0", cmd_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_single_word();
        words[0] = 16'h8001;
        send_frame(3'b101, 8'd1, 1);
        n_checks++;
        if (r_timeout !== 1'b0) $display("FAIL single_timeout: got %b want 0", r_timeout); else n_pass++;
        n_checks++;
        if (r_nbits !== 20) $display("FAIL single_busy_cycles: got %0d want 20", r_nbits); else n_pass++;
        n_checks++;
        if (r_bits !== 64'h0000_0000_0004_000D) $display("FAIL single_bits: got %h want %h", r_bits, 64'h0000_0000_0004_000D); else n_pass++;
        n_checks++;
        if (r_starts !== 1) $display("FAIL single_starts: got %0d want 1", r_starts); else n_pass++;
        n_checks++;
        if (r_dones !== 1 || r_tdone !== 19) $display("FAIL single_done: got %0d at %0d want 1 at 19", r_dones, r_tdone); else n_pass++;
        n_checks++;
        if (r_errs !== 0) $display("FAIL single_err: got %0d want 0", r_errs); else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL single_idle_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_zero_len();
        words[0] = 16'hBEEF;
        send_frame(3'b011, 8'd0, 1);
        n_checks++;
        if (r_nbits !== 4 || r_bits !== 64'h6) $display("FAIL zero_bits: got %0d bits %h want 4 bits 6", r_nbits, r_bits); else n_pass++;
        n_checks++;
        if (r_dones !== 1 || r_tdone !== 3) $display("FAIL zero_done: got %0d at %0d want 1 at 3", r_dones, r_tdone); else n_pass++;
        n_checks++;
        if (r_wrhi !== 0 || r_acc !== 0) $display("FAIL zero_wr_ready: got %0d/%0d want 0/0", r_wrhi, r_acc); else n_pass++;
        n_checks++;
        if (r_timeout !== 1'b0) $display("FAIL zero_timeout: got %b want 0", r_timeout); else n_pass++;
    endtask

    task automatic test_back_to_back_words();
        logic [63:0] exp_bits;
        words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'hA5A5; words[3] = 16'h1234;
        exp_bits = 64'h0005_2D2F_FFF8_000B;
        send_frame(3'b110, 8'd3, 4);
        n_checks++;
        if (r_nbits !== 52 || r_bits !== exp_bits) $display("FAIL three_bits: got %0d bits %h want 52 bits %h", r_nbits, r_bits, exp_bits); else n_pass++;
        n_checks++;
        if (r_acc !== 3) $display("FAIL three_accepted: got %0d want 3", r_acc); else n_pass++;
        n_checks++;
        if (r_wrtrace !== 8'b0001_0011) $display("FAIL three_wr_ready_trace: got %b want 00010011", r_wrtrace); else n_pass++;
        n_checks++;
        if (r_dones !== 1 || r_tdone !== 51 || r_errs !== 0) $display("FAIL three_status: done %0d at %0d err %0d want 1 at 51 err 0", r_dones, r_tdone, r_errs); else n_pass++;
    endtask

    task automatic test_underflow();
        words[0] = 16'h00FF;
        send_frame(3'b001, 8'd2, 1);
        n_checks++;
        if (r_errs !== 1 || r_terr !== 19) $display("FAIL underflow_err: got %0d at %0d want 1 at 19", r_errs, r_terr); else n_pass++;
        n_checks++;
        if (r_dones !== 0) $display("FAIL underflow_done: got %0d want 0", r_dones); else n_pass++;
        n_checks++;
        if (r_nbits !== 21 || r_bits !== 64'h7FC) $display("FAIL underflow_bits: got %0d bits %h want 21 bits 7fc", r_nbits, r_bits); else n_pass++;
        n_checks++;
        if (r_timeout !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL underflow_idle: timeout %b ready %b want 0 1", r_timeout, cmd_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int bad_pulse;
        bad_pulse = 0;
        cmd_id = 3'b100; cmd_len = 8'd2; cmd_valid = 1'b1;
        wr_valid = 1'b1; wr_data = 16'h0F0F;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (cfg_out_start !== 1'b1) $display("FAIL rst_mid_start: got %b want 1", cfg_out_start); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            bad_pulse += (done | err);
            tick();
        end
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rst_mid_busy: got %b want 1", busy); else n_pass++;
        crst = 1'b1;
        tick();
        bad_pulse += (done | err);
        n_checks++;
        if ({cfg_out_start, cfg_bit_out, busy, done, err, wr_ready, cmd_ready} !== 7'b0)
            $display("FAIL rst_mid_outputs: got %b want 0000000",
                     {cfg_out_start, cfg_bit_out, busy, done, err, wr_ready, cmd_ready});
        else n_pass++;
        crst = 1'b0; wr_valid = 1'b0;
        tick();
        bad_pulse += (done | err);
        n_checks++;
        if (cmd_ready !== 1'b1 || bad_pulse !== 0) $display("FAIL rst_mid_recover: ready %b pulses %0d want 1 0", cmd_ready, bad_pulse); else n_pass++;
        words[0] = 16'h0003;
        send_frame(3'b110, 8'd1, 1);
        n_checks++;
        if (r_nbits !== 20 || r_bits !== 64'h1B || r_dones !== 1 || r_errs !== 0)
            $display("FAIL rst_mid_next_frame: got %0d bits %h done %0d err %0d want 20 bits 1b done 1 err 0", r_nbits, r_bits, r_dones, r_errs);
        else n_pass++;
    endtask

    task automatic test_back_to_back_cmd();
        int first;
        int second;
        first = -1; second = -1;
        cmd_id = 3'b010; cmd_len = 8'd1; cmd_valid = 1'b1;
        wr_valid = 1'b1; wr_data = 16'h1234;
        for (int c = 0; c < 80 && second < 0; c++) begin
            if (cfg_out_start) begin
                if (first < 0) first = c;
                else second = c;
            end
            if (second < 0) tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (second < 0 || second - first !== 21) $display("FAIL b2b_start_spacing: got %0d want 21", second - first); else n_pass++;
        for (int c = 0; c < 60 && busy; c++) tick();
        wr_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_drain: busy %b want 0", busy); else n_pass++;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_word();
        test_zero_len();
        test_back_to_back_words();
        test_underflow();
        test_reset_mid_frame();
        test_back_to_back_cmd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
